decode_pipe_stage: RTL
======================

// Module: decode_pipe_stage
// PURPOSE
//  Registered, parametrised instruction-decode stage: accepts raw instructions via a valid/ready handshake,
//  decodes fields and class flags, extends the immediate, and inserts a one-cycle bubble on load-use hazards.
//  Sits between the fetch stage and the register-read/execute stage of the MIPS pipeline.
// PARAMETERS
//  DATA_W      32  instruction and extended-immediate width
//  OPCODE_W    6   opcode field width, instr[DATA_W-1 -: OPCODE_W]
//  REG_W       5   register-specifier width (rs, rt, rd fields)
//  IMM_W       16  immediate field width, instr[IMM_W-1:0]
//  CNT_W       16  width of the saturating stall counter
// PORTS
//  clk          in   1         clock, all state updates on rising edge
//  rst_n        in   1         synchronous active-low reset
//  flush        in   1         discard held instruction and hazard state
//  in_valid     in   1         in_instr is valid
//  in_ready     out  1         stage accepts in_instr this cycle
//  in_instr     in   DATA_W    raw instruction word
//  out_valid    out  1         decoded outputs are valid
//  out_ready    in   1         downstream accepts outputs this cycle
//  out_opcode   out  OPCODE_W  opcode field
//  out_rs/out_rt/out_rd out REG_W  register fields; out_rd = rd for R-type, rt for I-ALU/load, 0 otherwise
//  out_imm_ext  out  DATA_W    extended immediate (rules below)
//  out_is_alu/out_is_load/out_is_store/out_is_branch/out_illegal  out 1 each  class flags
//  stall_cnt    out  CNT_W     number of bubble cycles inserted, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, all out_* data/flags=0, stall_cnt=0, hz_pend=0.
//  - Latency 1: instruction accepted at edge N appears on outputs after edge N. Throughput 1/cycle.
//  - Accept = in_valid && in_ready. in_ready = (!out_valid || out_ready) && !hazard && !flush.
//  - Output register holds stable while out_valid && !out_ready (no data change, no drop).
//  - Classification: op=0 R-type ALU; 0x08-0x0F I-ALU; 0x20-0x25 load; 0x28-0x2B store;
//    0x04-0x07 branch; anything else out_illegal=1 (still passed downstream, other flags 0).
//  - Immediate: 0x0C-0x0E zero-extend; 0x0F (lui) imm << IMM_W; all others sign-extend to DATA_W.
//  - Source use: rs read by all classes except lui and illegal; rt read by R-type, store, 0x04/0x05.
//  - Load-use: when a load leaves (out_valid && out_ready), latch its dest rt and set hz_pend for
//    exactly the next cycle. hazard = hz_pend && in_valid && dest!=0 && (incoming reads rs==dest or rt==dest).
//  - On hazard: in_ready=0, out_valid drops to 0 (bubble), stall_cnt += 1 (saturate at all-ones),
//    hz_pend clears; instruction accepted on the following cycle. Register 0 never causes a hazard.
//  - hz_pend set and no match / no in_valid: hz_pend clears without a bubble or count.
//  - Back-to-back load then load-dependent: one bubble only; a second load re-arms hz_pend on its exit.
//  - flush (priority over accept and hazard): out_valid=0, hz_pend=0, no accept that cycle;
//    stall_cnt kept. Reset overrides flush.
//  - Reset mid-stream: held instruction discarded, no partial output; in_ready=0 while rst_n=0.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, stall_cnt=0.
//  2 Stream: addi $8,$9,-1 (0x2128FFFF) then ori $8,$9,0xFFFF (0x3528FFFF), out_ready=1 ->
//    1-cycle latency, out_imm_ext=0xFFFFFFFF then 0x0000FFFF, out_rd=8, out_is_alu=1.
//  3 Load-use: lw $8,0($9) (0x8D280000) then add $10,$8,$11 (0x010B5020) -> one bubble, stall_cnt=1;
//    repeat with lw $0 dest -> no bubble, stall_cnt unchanged.
//  4 Backpressure: out_ready=0 for 4 cycles mid-stream -> outputs stable, in_ready=0, nothing lost.
//  5 Flush: assert flush with out_valid=1 and hz_pend=1 -> out_valid=0 next cycle, next instr no bubble.
//  6 Random 1000 instrs, random out_ready -> reference-model compare of fields, flags, bubble count.

Source files
------------

// File: rtl/decode_pipe_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the decode stage.
// master drives instructions in and consumes decoded fields; slave is the stage itself.
interface decode_pipe_stage_if #(
    parameter int DATA_W   = 32,
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5
) ();
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] out_opcode;
    logic [REG_W-1:0]    out_rs;
    logic [REG_W-1:0]    out_rt;
    logic [REG_W-1:0]    out_rd;
    logic [DATA_W-1:0]   out_imm_ext;
    logic                out_is_alu;
    logic                out_is_load;
    logic                out_is_store;
    logic                out_is_branch;
    logic                out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm_ext,
               out_is_alu, out_is_load, out_is_store, out_is_branch, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm_ext,
               out_is_alu, out_is_load, out_is_store, out_is_branch, out_illegal
    );
endinterface

// File: rtl/decode_pipe_stage.sv
// MIPS decode stage: field split, class flags, immediate extension, load-use bubble insertion.
// Latency 1 cycle; output held stable under backpressure, in_ready low on hazard, flush or reset.
module decode_pipe_stage #(
    parameter int DATA_W   = 32,
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int IMM_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    decode_pipe_stage_if.slave   bus,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int RS_LSB = DATA_W - OPCODE_W - REG_W;
    localparam int RT_LSB = RS_LSB - REG_W;
    localparam int RD_LSB = RT_LSB - REG_W;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [DATA_W-1:0]   imm_ext;
        logic                is_alu;
        logic                is_load;
        logic                is_store;
        logic                is_branch;
        logic                illegal;
    } dec_t;

    dec_t              dec_q, dec_d, dec_new;
    logic              out_valid_q, out_valid_d;
    logic              hz_pend_q, hz_pend_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic [OPCODE_W-1:0] op;
    logic [IMM_W-1:0]    imm;
    logic                is_r, is_ialu, is_lui, is_zext, br_reads_rt;
    logic                reads_rs, reads_rt;
    logic                hazard, in_ready, accept, out_fire;

    always_comb begin
        dec_new     = '0;
        op          = bus.in_instr[DATA_W-1 -: OPCODE_W];
        imm         = bus.in_instr[IMM_W-1:0];
        is_r        = (op == '0);
        is_ialu     = (op >= OPCODE_W'(8))  && (op <= OPCODE_W'(15));
        is_lui      = (op == OPCODE_W'(15));
        is_zext     = (op >= OPCODE_W'(12)) && (op <= OPCODE_W'(14));
        br_reads_rt = (op == OPCODE_W'(4))  || (op == OPCODE_W'(5));

        dec_new.opcode    = op;
        dec_new.rs        = bus.in_instr[RS_LSB +: REG_W];
        dec_new.rt        = bus.in_instr[RT_LSB +: REG_W];
        dec_new.is_alu    = is_r || is_ialu;
        dec_new.is_load   = (op >= OPCODE_W'(32)) && (op <= OPCODE_W'(37));
        dec_new.is_store  = (op >= OPCODE_W'(40)) && (op <= OPCODE_W'(43));
        dec_new.is_branch = (op >= OPCODE_W'(4))  && (op <= OPCODE_W'(7));
        dec_new.illegal   = !(dec_new.is_alu || dec_new.is_load || dec_new.is_store || dec_new.is_branch);

        if (is_r) begin
            dec_new.rd = bus.in_instr[RD_LSB +: REG_W];
        end else if (is_ialu || dec_new.is_load) begin
            dec_new.rd = dec_new.rt;
        end

        if (is_lui) begin
            dec_new.imm_ext = DATA_W'(imm) << IMM_W;
        end else if (is_zext) begin
            dec_new.imm_ext = DATA_W'(imm);
        end else begin
            dec_new.imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end

        reads_rs = !dec_new.illegal && !is_lui;
        reads_rt = is_r || dec_new.is_store || br_reads_rt;
    end

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    always_comb begin
        hazard   = hz_pend_q && bus.in_valid && (dest_q != '0) &&
                   ((reads_rs && (dec_new.rs == dest_q)) || (reads_rt && (dec_new.rt == dest_q)));
        in_ready = rst_n && !flush && !hazard && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;
        out_fire = out_valid_q && bus.out_ready;

        out_valid_d = accept ? 1'b1 : (out_valid_q && !bus.out_ready);
        dec_d       = accept ? dec_new : dec_q;
        hz_pend_d   = out_fire && dec_q.is_load;
        dest_d      = (out_fire && dec_q.is_load) ? dec_q.rt : dest_q;
        stall_d     = stall_q;

        if (flush) begin
            out_valid_d = 1'b0;
            hz_pend_d   = 1'b0;
        end else if (hazard && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            hz_pend_q   <= 1'b0;
            dest_q      <= '0;
            stall_q     <= '0;
        end else begin
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            hz_pend_q   <= hz_pend_d;
            dest_q      <= dest_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_opcode    = dec_q.opcode;
    assign bus.out_rs        = dec_q.rs;
    assign bus.out_rt        = dec_q.rt;
    assign bus.out_rd        = dec_q.rd;
    assign bus.out_imm_ext   = dec_q.imm_ext;
    assign bus.out_is_alu    = dec_q.is_alu;
    assign bus.out_is_load   = dec_q.is_load;
    assign bus.out_is_store  = dec_q.is_store;
    assign bus.out_is_branch = dec_q.is_branch;
    assign bus.out_illegal   = dec_q.illegal;
    assign stall_cnt         = stall_q;
endmodule
